// File: rtl/id_pc_ctrl.sv
// ID-stage next-PC control: holds IF/ID, resolves beq/j/jr in ID, squashes the
// wrong-path fetch after a redirect and stalls fetch on load-use/branch hazards.
//
// state (stall_cnt) | meaning
// RUN     (0)       | no extra stall pending; stalls only while a hazard is live
// STALL_1 (1)       | second stall cycle of a beq/jr waiting on a load result
module id_pc_ctrl #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_4_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_dst,
  output logic [31:0] beq,
  output logic [31:0] jr,
  output logic [27:0] offset28,
  output logic [3:0]  pc_4_id,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic [31:0] if_id_pc_4,
  output logic [31:0] if_id_instr,
  output logic        bubble
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] STALL_1 = 2'd1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [1:0]  stall_cnt, stall_cnt_nxt;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic        is_beq, is_j, is_jr, is_br;
  logic        src_match, haz_load, haz, stall;

  assign op    = if_id_instr[31:26];
  assign rs    = if_id_instr[25:21];
  assign rt    = if_id_instr[20:16];
  assign imm   = if_id_instr[15:0];
  assign funct = if_id_instr[5:0];

  assign is_beq = (op == OP_BEQ);
  assign is_j   = (op == OP_J);
  assign is_jr  = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_br  = is_beq | is_jr;

  assign beq      = if_id_pc_4 + {{14{imm[15]}}, imm, 2'b00};
  assign jr       = rs_data;
  assign offset28 = {if_id_instr[25:0], 2'b00};
  assign pc_4_id  = if_id_pc_4[31:28];

  // $0 never carries a real dependency, so a zero destination cannot hazard.
  assign src_match = (ex_dst != 5'd0) && ((ex_dst == rs) || (ex_dst == rt));
  assign haz_load  = src_match && ex_mem_read;
  assign haz       = haz_load || (src_match && ex_reg_write && is_br);
  assign stall     = haz || (stall_cnt != RUN);

  assign pc_write = ~stall;
  assign bubble   = stall;

  always_comb begin
    pc_src = 2'b00;
    if (!stall) begin
      if (is_beq && (rs_data == rt_data)) pc_src = 2'b01;
      else if (is_jr)                     pc_src = 2'b10;
      else if (is_j)                      pc_src = 2'b11;
    end
  end

  // A branch on a load needs the load to clear MEM too, hence one extra cycle.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (stall_cnt != RUN)       stall_cnt_nxt = stall_cnt - 2'd1;
    else if (haz_load && is_br) stall_cnt_nxt = STALL_1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt   <= RUN;
      if_id_instr <= NOP_WORD;
      if_id_pc_4  <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (!stall) begin
        if_id_pc_4  <= pc_4_in;
        if_id_instr <= (pc_src != 2'b00) ? NOP_WORD : instr_in;
      end
    end
  end

endmodule

// File: doc/id_pc_ctrl.md
Name: id_pc_ctrl

Overview:
ID-side counterpart of the fetch stage. It holds the IF/ID pipeline register, decodes the held instruction and drives the fetch stage's next-PC controls: beq, jr, offset28, pc_4_id, pc_src and pc_write. It resolves beq/j/jr in ID, squashes the wrong-path fetch after a redirect, and stalls fetch on load-use and branch-operand hazards.

Parameters:
NOP_WORD, 32'h0000_0000, instruction word loaded into IF/ID on reset and on flush.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
pc_4_in  input  32  PC+4 from fetch stage (its pc_4_out)
instr_in  input  32  instruction fetched at pc_out
rs_data  input  32  register-file read of IF/ID instr[25:21]
rt_data  input  32  register-file read of IF/ID instr[20:16]
ex_mem_read  input  1  instruction in EX is a load
ex_reg_write  input  1  instruction in EX writes a register
ex_dst  input  5  destination register of the EX instruction
beq  output  32  branch target
jr  output  32  register jump target
offset28  output  28  jump offset
pc_4_id  output  4  upper PC bits for jumps
pc_src  output  2  00 = PC+4, 01 = beq, 10 = jr, 11 = {pc_4_id, offset28}
pc_write  output  1  1 = fetch PC may update
if_id_pc_4  output  32  registered PC+4
if_id_instr  output  32  registered instruction
bubble  output  1  1 = ID/EX must load a NOP this cycle

Behaviour:
- Decode of if_id_instr:
  - BEQ: op 000100.
  - J: op 000010.
  - JR: op 000000 with funct 001000.
  - LOADUSE: any instruction reading rs (instr[25:21]) or rt (instr[20:16]).
- Datapath outputs (combinational, every cycle):
  - beq = if_id_pc_4 + ({{14{imm[15]}}, imm16, 2'b00}), modulo 2^32.
  - jr = rs_data.
  - offset28 = {instr[25:0], 2'b00}.
  - pc_4_id = if_id_pc_4[31:28].
- Hazard detect (haz), requires ex_dst != 0 and ex_dst matching rs or rt of the ID instruction:
  - ex_mem_read with a match → haz.
  - ex_reg_write with a match and the ID instruction is BEQ or JR → haz.
- Stall counter stall_cnt (2 bits), FSM states:
  - RUN (cnt=0).
  - STALL (cnt>0).
- In RUN:
  - A load hazard on a BEQ/JR → cnt=1 at the next edge, giving 2 stall cycles total.
  - Any other haz → cnt stays 0, giving 1 stall cycle.
  - In STALL, cnt decrements each edge.
- stall = haz | (cnt != 0).
- stall = 1:
  - pc_write = 0, pc_src = 00, bubble = 1.
  - IF/ID holds its value.
  - No redirect.
- stall = 0:
  - pc_write = 1, bubble = 0.
  - pc_src = 01 if BEQ and rs_data == rt_data; 10 if JR; 11 if J; else 00.
- Flush: stall = 0 and pc_src != 00 → at the next edge if_id_instr ← NOP_WORD and if_id_pc_4 ← pc_4_in. The wrong-path fetch is squashed, so a redirect costs exactly 1 bubble.
- Normal load: stall = 0 and pc_src = 00 → IF/ID ← {pc_4_in, instr_in}.
- Priority: reset > stall > flush > normal load.
- Reset (async, any time, including mid-stall):
  - if_id_instr = NOP_WORD, if_id_pc_4 = 0, cnt = 0.
  - Outputs settle to pc_write = 1, pc_src = 00, bubble = 0, beq = 0, offset28 = 0, pc_4_id = 0.
- Back-to-back redirects cannot occur, because the flushed slot is a NOP.
- A BEQ with a negative offset wraps modulo 2^32.

Test Plan:
- Reset asserted mid-run → if_id_instr = 0, if_id_pc_4 = 0, pc_write = 1, pc_src = 00; after release, pc_4_in = 32'h4 / instr_in = 32'h2002_0005 is captured on the next edge.
- BEQ $1,$1,+3 at if_id_pc_4 = 32'h10, rs_data = rt_data = 7 → beq = 32'h1C, pc_src = 01; next edge if_id_instr = 0. Repeat with rs_data ≠ rt_data → pc_src = 00, no flush.
- J with target field 26'h3FFFFFF, if_id_pc_4 = 32'hA000_0008 → offset28 = 28'hFFFFFFC, pc_4_id = 4'hA, pc_src = 11, flush next edge.
- Load-use: ex_mem_read = 1, ex_dst = 5, ID add reading $5 → exactly 1 cycle of pc_write = 0 and bubble = 1, with IF/ID held; ex_dst = 0 → no stall.
- Branch-on-load: ID beq $5,$6, ex_mem_read = 1, ex_dst = 6 → 2 stall cycles, then pc_src resolves. Assert reset during the second stall cycle → cnt cleared and pc_write = 1 immediately.
- JR $31, rs_data = 32'h0000_0F00, with ex_reg_write = 1 and ex_dst = 31 → 1 stall; then jr = 32'hF00, pc_src = 10, flush.
